devil_addr_sweeper: RTL and testbench
=====================================

// Module: devil_addr_sweeper
// PURPOSE
//  Upstream sequencer for the active snoop engine: walks a cache-line-aligned window [base, base+size)
//  one line at a time, presents each line address and raises the active trigger, waits for the engine's
//  one-cycle reply, releases the trigger so the engine re-arms, waits a programmable gap, then advances.
//  Owns the trigger/reply handshake, line counting, abort and a per-line watchdog.
// PARAMETERS
//  C_S_AXI_DATA_WIDTH  32     width of the AXI-Lite config register inputs
//  C_ACE_ADDR_WIDTH    44     ACE address width; o_acaddr width
//  LINE_BYTES          64     cache line size in bytes; power of two
//  TIMEOUT_CYCLES      4096   max cycles in TRIG without i_reply before error; >= 16
// PORTS
//  ace_aclk          in   1    clock
//  ace_areset        in   1    synchronous reset, active-high
//  i_start           in   1    one-cycle sweep start; sampled only in IDLE
//  i_abort           in   1    one-cycle abort request; sampled in every state except IDLE
//  i_base_addr_reg   in   32   window base address in bytes, zero-extended to C_ACE_ADDR_WIDTH
//  i_addr_size_reg   in   32   window size in bytes; 0 = empty window
//  i_delay_reg       in   32   idle gap in cycles between lines, after trigger release
//  i_reply           in   1    engine reply pulse; marks line complete
//  i_busy            in   1    engine not idle
//  o_trigger_active  out  1    level trigger to the engine
//  o_acaddr          out  44   current line address, LINE_BYTES-aligned
//  o_sweeping        out  1    high from ARM until DONE, inclusive
//  o_done            out  1    one-cycle pulse at sweep end (normal, abort or error)
//  o_line_count      out  32   lines completed in the current sweep
//  o_aborted         out  1    sticky; set by abort; cleared by the next accepted i_start
//  o_timeout_err     out  1    sticky; set by watchdog expiry; cleared by the next accepted i_start
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, counters 0. Reset mid-sweep drops the trigger on the next edge.
//  States: IDLE, ARM, TRIG, RELEASE, GAP, NEXT, DRAIN, DONE.
//  IDLE: on i_start, capture the registers; clear line_count, aborted and timeout_err; go to ARM.
//  ARM: start = base & ~(LINE_BYTES-1).
//   - nlines = (off + size + LINE_BYTES-1) >> log2(LINE_BYTES), where off = base & (LINE_BYTES-1).
//   - Compute nlines in 34-bit arithmetic, with no overflow at size = 0xFFFF_FFFF.
//   - nlines = 0 goes to DONE. Otherwise load o_acaddr = start and go to TRIG.
//  TRIG: o_trigger_active = 1, so the trigger rises 2 cycles after i_start is sampled. Watchdog counts up.
//   - i_reply goes to RELEASE and increments line_count in the same edge.
//   - Watchdog reaching TIMEOUT_CYCLES: set timeout_err, drop trigger, go to DONE.
//   - i_abort: set aborted and go to DRAIN. The engine is never cut off mid-transaction.
//  RELEASE: trigger 0 for at least 1 cycle so the engine clears its end flag. Stay while i_busy=1.
//   - Then go to GAP, or to NEXT if i_delay_reg = 0.
//  GAP: down-counter loaded with the delay value; go to NEXT when it reaches 1. Exactly `delay` cycles.
//  NEXT: if line_count == nlines, go to DONE.
//   - Otherwise o_acaddr += LINE_BYTES, modulo 2^C_ACE_ADDR_WIDTH (wrap is silent), and go to TRIG.
//  DRAIN: trigger stays 1 until i_reply (line_count increments) or watchdog expiry (timeout_err), then DONE.
//  DONE: o_done = 1 for one cycle; o_sweeping drops in the same edge; go to IDLE.
//  Abort in RELEASE, GAP or NEXT sets aborted and goes directly to DONE.
//  i_start while not IDLE is ignored.
//  i_abort and i_reply together in TRIG: the reply is counted, aborted is set, and the block goes to DONE.
//  Register inputs are captured at start; later writes do not affect the current sweep.
//  o_acaddr holds the last line address after DONE.
// STRUCTURE
//  devil_in_fpga.vh gains: SWEEP_* state encodings (3 bits) and the LINE_SHIFT localparam derived from LINE_BYTES.
//  One sub-module: devil_cycle_counter (loadable down-counter with zero flag), instanced twice: GAP delay and TRIG/DRAIN watchdog.
//  FSM, address and line arithmetic stay in this module.
// TESTING
//  Bench model of the engine: after trigger rise, wait N cycles, then pulse reply. The model re-arms only after trigger low.
//  1. base=0x1000, size=0x100, delay=0, N=5:
//     -> 4 triggers at 0x1000, 0x1040, 0x1080, 0x10C0; line_count=4; one o_done; no error flags.
//  2. base=0x103C, size=8:
//     -> 2 lines, at 0x1000 and 0x1040.
//     Same base with size=0 -> o_done 2 cycles after i_start, no trigger, line_count=0.
//  3. delay=10:
//     -> exactly 10 GAP cycles between trigger fall (plus RELEASE) and the next rise.
//     Trigger low for at least 1 cycle between every line.
//  4. Abort during TRIG of line 2 of 4:
//     -> trigger held until reply; line_count=2; o_aborted=1; one o_done. Next i_start clears o_aborted.
//  5. Model never replies:
//     -> after TIMEOUT_CYCLES, o_timeout_err=1, trigger=0, o_done pulse.
//     Reset asserted mid-TRIG -> all outputs 0 next cycle.
//  6. base=0xFFFF_FFC0, size=0xFFFF_FFFF:
//     -> nlines computed without overflow; second address 0x1_0000_0000.
//     i_start while sweeping -> no effect.

Source files
------------

// File: rtl/devil_addr_sweeper_pkg.sv
// Shared types and helpers for the snoop address sweeper.
package devil_addr_sweeper_pkg;

  localparam int unsigned SWEEP_STATE_W = 3;

  typedef enum logic [SWEEP_STATE_W-1:0] {
    SWEEP_IDLE    = 3'd0,
    SWEEP_ARM     = 3'd1,
    SWEEP_TRIG    = 3'd2,
    SWEEP_RELEASE = 3'd3,
    SWEEP_GAP     = 3'd4,
    SWEEP_NEXT    = 3'd5,
    SWEEP_DRAIN   = 3'd6,
    SWEEP_DONE    = 3'd7
  } sweep_state_e;

  function automatic int unsigned line_shift(input int unsigned line_bytes);
    return $clog2(line_bytes);
  endfunction

endpackage

// File: rtl/devil_cycle_counter.sv
// Loadable down-counter that saturates at zero; used for gap delay and watchdog.
module devil_cycle_counter #(
  parameter int unsigned W = 32
) (
  input  logic         ace_aclk,
  input  logic         ace_areset,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         zero_c
);

  logic [W-1:0] count;

  always_ff @(posedge ace_aclk) begin
    if (ace_areset)
      count <= '0;
    else if (load)
      count <= load_val;
    else if (en && (count != '0))
      count <= count - W'(1);
  end

  assign zero_c = (count == '0);

endmodule

// File: rtl/devil_addr_sweeper.sv
// Walks a line-aligned window, driving the snoop engine trigger one line at a time.
module devil_addr_sweeper
  import devil_addr_sweeper_pkg::*;
#(
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_ACE_ADDR_WIDTH   = 44,
  parameter int unsigned LINE_BYTES         = 64,
  parameter int unsigned TIMEOUT_CYCLES     = 4096
) (
  input  logic                          ace_aclk,
  input  logic                          ace_areset,
  input  logic                          i_start,
  input  logic                          i_abort,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] i_base_addr_reg,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] i_addr_size_reg,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] i_delay_reg,
  input  logic                          i_reply,
  input  logic                          i_busy,
  output logic                          o_trigger_active,
  output logic [C_ACE_ADDR_WIDTH-1:0]   o_acaddr,
  output logic                          o_sweeping,
  output logic                          o_done,
  output logic [31:0]                   o_line_count,
  output logic                          o_aborted,
  output logic                          o_timeout_err
);

  localparam int unsigned DW         = C_S_AXI_DATA_WIDTH;
  localparam int unsigned AW         = C_ACE_ADDR_WIDTH;
  localparam int unsigned NW         = DW + 2;
  localparam int unsigned LINE_SHIFT = line_shift(LINE_BYTES);
  localparam int unsigned WD_W       = $clog2(TIMEOUT_CYCLES + 1);

  sweep_state_e  state;
  logic [DW-1:0] base_q, size_q, delay_q;
  logic [NW-1:0] nlines_q, nlines_c;
  logic [AW-1:0] start_c;
  logic          wd_load, wd_en, wd_zero_c;
  logic          gap_load, gap_en, gap_zero_c;

  // Two guard bits keep offset + size + rounding from overflowing.
  always_comb begin
    nlines_c = '0;
    if (size_q != '0)
      nlines_c = ((NW'(base_q) & NW'(LINE_BYTES - 1)) + NW'(size_q)
                  + NW'(LINE_BYTES - 1)) >> LINE_SHIFT;
  end

  assign start_c  = AW'(base_q) & ~AW'(LINE_BYTES - 1);
  assign wd_load  = (state == SWEEP_ARM) || (state == SWEEP_NEXT);
  assign wd_en    = (state == SWEEP_TRIG) || (state == SWEEP_DRAIN);
  assign gap_load = (state == SWEEP_RELEASE);
  assign gap_en   = (state == SWEEP_GAP);

  devil_cycle_counter #(.W(WD_W)) u_watchdog (
    .ace_aclk   (ace_aclk),
    .ace_areset (ace_areset),
    .load       (wd_load),
    .en         (wd_en),
    .load_val   (WD_W'(TIMEOUT_CYCLES - 1)),
    .zero_c     (wd_zero_c)
  );

  devil_cycle_counter #(.W(DW)) u_gap (
    .ace_aclk   (ace_aclk),
    .ace_areset (ace_areset),
    .load       (gap_load),
    .en         (gap_en),
    .load_val   (delay_q - DW'(1)),
    .zero_c     (gap_zero_c)
  );

  always_ff @(posedge ace_aclk) begin
    if (ace_areset) begin
      state            <= SWEEP_IDLE;
      base_q           <= '0;
      size_q           <= '0;
      delay_q          <= '0;
      nlines_q         <= '0;
      o_trigger_active <= 1'b0;
      o_acaddr         <= '0;
      o_sweeping       <= 1'b0;
      o_done           <= 1'b0;
      o_line_count     <= '0;
      o_aborted        <= 1'b0;
      o_timeout_err    <= 1'b0;
    end else begin
      o_done <= 1'b0;
      unique case (state)
        SWEEP_IDLE: begin
          if (i_start) begin
            base_q        <= i_base_addr_reg;
            size_q        <= i_addr_size_reg;
            delay_q       <= i_delay_reg;
            o_line_count  <= '0;
            o_aborted     <= 1'b0;
            o_timeout_err <= 1'b0;
            o_sweeping    <= 1'b1;
            state         <= SWEEP_ARM;
          end
        end
        SWEEP_ARM: begin
          nlines_q <= nlines_c;
          if (i_abort) begin
            o_aborted <= 1'b1;
            o_done    <= 1'b1;
            state     <= SWEEP_DONE;
          end else if (nlines_c == '0) begin
            o_done <= 1'b1;
            state  <= SWEEP_DONE;
          end else begin
            o_acaddr         <= start_c;
            o_trigger_active <= 1'b1;
            state            <= SWEEP_TRIG;
          end
        end
        SWEEP_TRIG: begin
          if (i_abort) o_aborted <= 1'b1;
          if (i_reply) begin
            o_line_count     <= o_line_count + 32'd1;
            o_trigger_active <= 1'b0;
            if (i_abort) begin
              o_done <= 1'b1;
              state  <= SWEEP_DONE;
            end else begin
              state <= SWEEP_RELEASE;
            end
          end else if (wd_zero_c) begin
            o_timeout_err    <= 1'b1;
            o_trigger_active <= 1'b0;
            o_done           <= 1'b1;
            state            <= SWEEP_DONE;
          end else if (i_abort) begin
            state <= SWEEP_DRAIN;
          end
        end
        // Abort must not cut the engine off mid-line; hold the trigger until it answers.
        SWEEP_DRAIN: begin
          if (i_reply) begin
            o_line_count     <= o_line_count + 32'd1;
            o_trigger_active <= 1'b0;
            o_done           <= 1'b1;
            state            <= SWEEP_DONE;
          end else if (wd_zero_c) begin
            o_timeout_err    <= 1'b1;
            o_trigger_active <= 1'b0;
            o_done           <= 1'b1;
            state            <= SWEEP_DONE;
          end
        end
        SWEEP_RELEASE: begin
          if (i_abort) begin
            o_aborted <= 1'b1;
            o_done    <= 1'b1;
            state     <= SWEEP_DONE;
          end else if (!i_busy) begin
            state <= (delay_q == '0) ? SWEEP_NEXT : SWEEP_GAP;
          end
        end
        SWEEP_GAP: begin
          if (i_abort) begin
            o_aborted <= 1'b1;
            o_done    <= 1'b1;
            state     <= SWEEP_DONE;
          end else if (gap_zero_c) begin
            state <= SWEEP_NEXT;
          end
        end
        SWEEP_NEXT: begin
          if (i_abort) begin
            o_aborted <= 1'b1;
            o_done    <= 1'b1;
            state     <= SWEEP_DONE;
          end else if (NW'(o_line_count) == nlines_q) begin
            o_done <= 1'b1;
            state  <= SWEEP_DONE;
          end else begin
            o_acaddr         <= o_acaddr + AW'(LINE_BYTES);
            o_trigger_active <= 1'b1;
            state            <= SWEEP_TRIG;
          end
        end
        SWEEP_DONE: begin
          o_sweeping <= 1'b0;
          state      <= SWEEP_IDLE;
        end
        default: state <= SWEEP_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_devil_addr_sweeper.sv
// Self-checking bench: random sweeps against a window/line reference model and an engine model.
module tb_devil_addr_sweeper;

  localparam int unsigned TO = 64;

  logic        ace_aclk = 1'b0;
  logic        ace_areset, i_start, i_abort, i_reply, i_busy;
  logic [31:0] i_base_addr_reg, i_addr_size_reg, i_delay_reg;
  logic        o_trigger_active, o_sweeping, o_done, o_aborted, o_timeout_err;
  logic [43:0] o_acaddr;
  logic [31:0] o_line_count;

  devil_addr_sweeper #(.TIMEOUT_CYCLES(TO)) dut (
    .ace_aclk         (ace_aclk),
    .ace_areset       (ace_areset),
    .i_start          (i_start),
    .i_abort          (i_abort),
    .i_base_addr_reg  (i_base_addr_reg),
    .i_addr_size_reg  (i_addr_size_reg),
    .i_delay_reg      (i_delay_reg),
    .i_reply          (i_reply),
    .i_busy           (i_busy),
    .o_trigger_active (o_trigger_active),
    .o_acaddr         (o_acaddr),
    .o_sweeping       (o_sweeping),
    .o_done           (o_done),
    .o_line_count     (o_line_count),
    .o_aborted        (o_aborted),
    .o_timeout_err    (o_timeout_err)
  );

  always #5 ace_aclk = ~ace_aclk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Cycle counter and trigger/done monitor
  int cyc = 0;
  always @(posedge ace_aclk) cyc <= cyc + 1;

  logic [63:0] rise_q[$];
  int          rise_cyc_q[$];
  int          low_q[$];
  int          high_q[$];
  int          done_cnt = 0;
  int          last_done_cyc = 0;
  int          low_run = 0;
  int          high_run = 0;
  logic        prev_trig = 1'b0;

  always @(negedge ace_aclk) begin
    if (o_trigger_active) begin
      if (!prev_trig) begin
        rise_q.push_back(64'(o_acaddr));
        rise_cyc_q.push_back(cyc);
        low_q.push_back(low_run);
      end
      high_run = high_run + 1;
      low_run  = 0;
    end else begin
      if (prev_trig) high_q.push_back(high_run);
      high_run = 0;
      low_run  = low_run + 1;
    end
    prev_trig = o_trigger_active;
    if (o_done) begin
      done_cnt      = done_cnt + 1;
      last_done_cyc = cyc;
    end
  end

  // Engine model: reply eng_lat cycles after trigger rise, stay busy eng_tail more, re-arm on trigger low.
  int eng_lat  = 5;
  int eng_tail = 0;
  bit eng_mute = 1'b0;

  initial begin
    int st  = 0;
    int cnt = 0;
    i_reply = 1'b0;
    i_busy  = 1'b0;
    forever begin
      @(posedge ace_aclk);
      #1;
      i_reply = 1'b0;
      if (ace_areset) begin
        st = 0; i_busy = 1'b0;
      end else begin
        case (st)
          0: if (o_trigger_active) begin
               cnt = eng_lat; i_busy = 1'b1; st = 1;
             end
          1: if (!o_trigger_active) begin
               i_busy = 1'b0; st = 0;
             end else begin
               cnt = cnt - 1;
               if (cnt <= 0 && !eng_mute) begin
                 i_reply = 1'b1; st = 2;
               end
             end
          2: begin
               cnt = eng_tail;
               if (cnt == 0) begin i_busy = 1'b0; st = 3; end
               else st = 4;
             end
          4: begin
               cnt = cnt - 1;
               if (cnt == 0) begin i_busy = 1'b0; st = 3; end
             end
          default: if (!o_trigger_active) st = 0;
        endcase
      end
    end
  end

  task automatic start_sweep(input logic [31:0] base, size, delay, output int st_cyc);
    @(negedge ace_aclk);
    i_base_addr_reg = base;
    i_addr_size_reg = size;
    i_delay_reg     = delay;
    i_start         = 1'b1;
    st_cyc          = cyc;
    @(negedge ace_aclk);
    i_start = 1'b0;
  endtask

  task automatic pulse_abort();
    @(negedge ace_aclk);
    i_abort = 1'b1;
    @(negedge ace_aclk);
    i_abort = 1'b0;
  endtask

  task automatic wait_done(input int target, input int bound);
    int k = 0;
    while (done_cnt < target && k < bound) begin
      @(negedge ace_aclk);
      k++;
    end
    if (done_cnt < target) check_eq("done_wait_expired", 64'(done_cnt), 64'(target));
  endtask

  task automatic wait_rises(input int target, input int bound);
    int k = 0;
    while (rise_q.size() < target && k < bound) begin
      @(negedge ace_aclk);
      k++;
    end
    if (rise_q.size() < target) check_eq("rise_wait_expired", 64'(rise_q.size()), 64'(target));
  endtask

  // Reference: window [base, base+size) touches ceil-aligned lines; empty window sweeps nothing.
  task automatic sweep_check(input logic [31:0] base, size, delay, input int lat, tail);
    int s_rise, s_done, st;
    logic [63:0] n, start;
    s_rise   = rise_q.size();
    s_done   = done_cnt;
    eng_lat  = lat;
    eng_tail = tail;
    n     = (size == 0) ? 64'd0 : ((64'(base & 32'h3F) + 64'(size) + 64'd63) >> 6);
    start = 64'(base & ~32'h3F);
    start_sweep(base, size, delay, st);
    wait_done(s_done + 1, 8000);
    repeat (3) @(negedge ace_aclk);
    check_eq("num_lines", 64'(rise_q.size() - s_rise), n);
    for (int i = 0; i < int'(n) && s_rise + i < rise_q.size(); i++) begin
      check_eq("line_addr", rise_q[s_rise + i], start + 64'(i) * 64);
      if (i > 0) check_eq("low_gap", 64'(low_q[s_rise + i]), 64'(tail + int'(delay) + 2));
    end
    check_eq("line_count", 64'(o_line_count), n);
    check_eq("done_pulses", 64'(done_cnt - s_done), 64'd1);
    check_eq("aborted", 64'(o_aborted), 64'd0);
    check_eq("timeout_err", 64'(o_timeout_err), 64'd0);
    check_eq("sweeping_end", 64'(o_sweeping), 64'd0);
    if (n != 0) begin
      if (s_rise < rise_cyc_q.size())
        check_eq("trig_latency", 64'(rise_cyc_q[s_rise] - st), 64'd2);
      check_eq("acaddr_hold", 64'(o_acaddr), start + (n - 1) * 64);
    end else begin
      check_eq("empty_done_latency", 64'(last_done_cyc - st), 64'd2);
    end
  endtask

  initial begin
    int s_rise, s_high, s_done, st;
    ace_areset      = 1'b1;
    i_start         = 1'b0;
    i_abort         = 1'b0;
    i_base_addr_reg = '0;
    i_addr_size_reg = '0;
    i_delay_reg     = '0;
    repeat (3) @(negedge ace_aclk);
    check_eq("rst_trigger", 64'(o_trigger_active), 64'd0);
    check_eq("rst_acaddr", 64'(o_acaddr), 64'd0);
    check_eq("rst_flags", 64'({o_sweeping, o_done, o_aborted, o_timeout_err}), 64'd0);
    check_eq("rst_line_count", 64'(o_line_count), 64'd0);
    ace_areset = 1'b0;

    // Directed windows: aligned, straddling, empty, long gap
    sweep_check(32'h1000, 32'h100, 32'd0, 5, 0);
    sweep_check(32'h103C, 32'd8, 32'd0, 3, 1);
    sweep_check(32'h103C, 32'd0, 32'd0, 3, 0);
    sweep_check(32'h2000, 32'h0C0, 32'd10, 4, 1);

    // Abort during TRIG of line 2 of 4
    s_rise = rise_q.size(); s_high = high_q.size(); s_done = done_cnt;
    eng_lat = 6; eng_tail = 0;
    start_sweep(32'h4000, 32'h100, 32'd2, st);
    wait_rises(s_rise + 2, 500);
    pulse_abort();
    wait_done(s_done + 1, 500);
    repeat (3) @(negedge ace_aclk);
    check_eq("abort_line_count", 64'(o_line_count), 64'd2);
    check_eq("abort_flag", 64'(o_aborted), 64'd1);
    check_eq("abort_done", 64'(done_cnt - s_done), 64'd1);
    check_eq("abort_lines", 64'(rise_q.size() - s_rise), 64'd2);
    if (high_q.size() > s_high + 1)
      check_eq("abort_trig_held", 64'(high_q[s_high + 1]), 64'd7);
    else
      check_eq("abort_fall_seen", 64'(high_q.size() - s_high), 64'd2);
    sweep_check(32'h5040, 32'h40, 32'd1, 2, 0);

    // Silent engine: watchdog expiry
    s_rise = rise_q.size(); s_high = high_q.size(); s_done = done_cnt;
    eng_mute = 1'b1;
    start_sweep(32'h3000, 32'h80, 32'd0, st);
    wait_done(s_done + 1, 1000);
    repeat (2) @(negedge ace_aclk);
    check_eq("to_err", 64'(o_timeout_err), 64'd1);
    check_eq("to_trigger", 64'(o_trigger_active), 64'd0);
    check_eq("to_lines", 64'(rise_q.size() - s_rise), 64'd1);
    check_eq("to_line_count", 64'(o_line_count), 64'd0);
    if (high_q.size() > s_high)
      check_eq("to_trig_len", 64'(high_q[s_high]), 64'(TO));
    else
      check_eq("to_fall_seen", 64'(high_q.size() - s_high), 64'd1);

    // Reset mid-TRIG
    s_rise = rise_q.size();
    start_sweep(32'h3000, 32'h80, 32'd0, st);
    wait_rises(s_rise + 1, 100);
    repeat (4) @(negedge ace_aclk);
    ace_areset = 1'b1;
    @(negedge ace_aclk);
    check_eq("midrst_trigger", 64'(o_trigger_active), 64'd0);
    check_eq("midrst_outs", 64'({o_sweeping, o_done, o_aborted, o_timeout_err}), 64'd0);
    check_eq("midrst_acaddr", 64'(o_acaddr), 64'd0);
    ace_areset = 1'b0;
    eng_mute   = 1'b0;

    // Huge window from top of 32-bit space; start while sweeping is ignored
    s_rise = rise_q.size(); s_done = done_cnt;
    eng_lat = 3; eng_tail = 0;
    start_sweep(32'hFFFF_FFC0, 32'hFFFF_FFFF, 32'd0, st);
    wait_rises(s_rise + 2, 200);
    @(negedge ace_aclk);
    i_base_addr_reg = 32'h0; i_addr_size_reg = 32'h40; i_start = 1'b1;
    @(negedge ace_aclk);
    i_start = 1'b0;
    wait_rises(s_rise + 3, 200);
    pulse_abort();
    wait_done(s_done + 1, 500);
    repeat (2) @(negedge ace_aclk);
    if (rise_q.size() >= s_rise + 3) begin
      check_eq("wide_addr0", rise_q[s_rise], 64'h0_FFFF_FFC0);
      check_eq("wide_addr1", rise_q[s_rise + 1], 64'h1_0000_0000);
      check_eq("wide_addr2", rise_q[s_rise + 2], 64'h1_0000_0040);
    end
    check_eq("wide_line_count", 64'(o_line_count), 64'd3);
    check_eq("wide_aborted", 64'(o_aborted), 64'd1);
    check_eq("wide_done", 64'(done_cnt - s_done), 64'd1);

    // Random windows
    for (int t = 0; t < 8; t++) begin
      sweep_check($urandom(), $urandom_range(0, 32'h200), $urandom_range(0, 5),
                  int'($urandom_range(1, 6)), int'($urandom_range(0, 2)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
